hex_uart_tx: RTL and testbench

HEX_UART_TX -- requirements
Module: hex_uart_tx

---
 rtl/hex_uart_tx_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 88 ++++++++
 rtl/hex_uart_tx.sv | 102 ++++++++++
 tb/tb_hex_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_uart_tx_pkg.sv
// Shared definitions for the hex-printing UART transmitter: serializer states,
// line terminator characters and default bit timing.
package hex_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0]  ASCII_CR             = 8'h0D;
  localparam logic [7:0]  ASCII_LF             = 8'h0A;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int          BAUD_W               = 16;
  localparam logic [2:0]  LAST_CHAR            = 3'd5;
  localparam logic [2:0]  LAST_BIT             = 3'd7;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. done_o marks the final stop-bit cycle so the caller can
// chain the next byte into START on the same edge with no idle gap.
module uart_tx_byte
  import hex_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       tx_o
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign done_o  = (state_q == ST_STOP) && bit_end;
  assign tx_o    = tx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      baud_q <= bit_end ? '0 : baud_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          if (start_i) begin
            state_q <= ST_START;
            shift_q <= data_i;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_q == LAST_BIT) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            // Back-to-back chaining: a pending byte goes straight to START.
            if (start_i) begin
              state_q <= ST_START;
              shift_q <= data_i;
              bit_q   <= '0;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/hex_uart_tx.sv
// Prints each accepted 16-bit word as four uppercase hex characters plus CR LF
// over a UART line, feeding the byte serializer one character at a time.
module hex_uart_tx
  import hex_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy
);

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'hA) return 8'h30 + {4'h0, nib};
    else            return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] line_char(input logic [15:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    return hex_ascii(w[15:12]);
      3'd1:    return hex_ascii(w[11:8]);
      3'd2:    return hex_ascii(w[7:4]);
      3'd3:    return hex_ascii(w[3:0]);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  logic [15:0] word_q, word_d;
  logic [2:0]  char_idx_q, char_idx_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        accept;
  logic        byte_start;
  logic [7:0]  byte_data;
  logic        byte_done;
  logic [2:0]  char_next;

  assign accept     = word_valid && ready_q;
  assign char_next  = char_idx_q + 3'd1;
  assign word_ready = ready_q;
  assign busy       = busy_q;

  always_comb begin
    word_d     = word_q;
    char_idx_d = char_idx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    byte_start = 1'b0;
    byte_data  = '0;
    if (accept) begin
      // word_q is not loaded yet, so the first character comes from word_in.
      word_d     = word_in;
      char_idx_d = '0;
      busy_d     = 1'b1;
      ready_d    = 1'b0;
      byte_start = 1'b1;
      byte_data  = line_char(word_in, 3'd0);
    end else if (busy_q && byte_done) begin
      if (char_idx_q == LAST_CHAR) begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end else begin
        char_idx_d = char_next;
        byte_start = 1'b1;
        byte_data  = line_char(word_q, char_next);
      end
    end else if (!busy_q) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q     <= '0;
      char_idx_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      word_q     <= word_d;
      char_idx_q <= char_idx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(byte_start),
    .data_i (byte_data),
    .done_o (byte_done),
    .tx_o   (tx)
  );

endmodule

// File: tb/tb_hex_uart_tx.sv
// Randomized and directed checks of hex_uart_tx against a waveform model derived
// from the character/frame arithmetic of the line format.
module tb_hex_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] win4 = '0, win2 = '0;
  logic        val4 = 1'b0, val2 = 1'b0;
  logic        ready4, tx4, busy4, ready2, tx2, busy2;

  hex_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .word_in(win4), .word_valid(val4),
    .word_ready(ready4), .tx(tx4), .busy(busy4));

  hex_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .word_in(win2), .word_valid(val2),
    .word_ready(ready2), .tx(tx2), .busy(busy2));

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  logic  tx_s   [0:1023];
  logic  busy_s [0:1023];
  logic  rdy_s  [0:1023];
  string hexs = "0123456789ABCDEF";

  function automatic logic [7:0] exp_char(input logic [15:0] w, input int idx);
    int  n;
    byte c;
    if (idx < 4) begin
      n = int'((w >> (12 - 4 * idx)) & 16'hF);
      c = hexs[n];
      return 8'(c);
    end
    if (idx == 4) return 8'h0D;
    return 8'h0A;
  endfunction

  // Expected line level k cycles after acceptance (k=0 is the first start-bit cycle).
  function automatic logic exp_tx(input logic [15:0] w, input int k, input int n);
    int b, j, p;
    logic [7:0] c;
    b = k / n;
    j = b / 10;
    p = b % 10;
    if (j > 5)  return 1'b1;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    c = exp_char(w, j);
    return c[p-1];
  endfunction

  function automatic int wave_errs(input int off, input logic [15:0] w, input int n);
    int e = 0;
    for (int k = 0; k < 60 * n; k++)
      if (tx_s[off + k] !== exp_tx(w, k, n)) e++;
    return e;
  endfunction

  function automatic logic [7:0] decode(input int off, input int j, input int n);
    logic [7:0] d;
    for (int b = 0; b < 8; b++) d[b] = tx_s[off + (j * 10 + 1 + b) * n + n / 2];
    return d;
  endfunction

  function automatic int count_hi(input int sel, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (sel == 0 && busy_s[i] === 1'b1) c++;
      if (sel == 1 && rdy_s[i] === 1'b1) c++;
      if (sel == 2 && rdy_s[i] === 1'b1 && busy_s[i] === 1'b1) c++;
      if (sel == 3 && tx_s[i] !== 1'b1) c++;
    end
    return c;
  endfunction

  task automatic capture(input bit use2, input int n, input bit drop0, input int chg_at,
                         input logic [15:0] chg_word, input bit chg_valid, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_s[i]   = use2 ? tx2 : tx4;
      busy_s[i] = use2 ? busy2 : busy4;
      rdy_s[i]  = use2 ? ready2 : ready4;
      if (drop0 && i == 0) begin
        if (use2) val2 = 1'b0; else val4 = 1'b0;
      end
      if (i == chg_at) begin
        if (use2) begin win2 = chg_word; val2 = chg_valid; end
        else begin win4 = chg_word; val4 = chg_valid; end
      end
      if (i == drop_at) begin
        if (use2) val2 = 1'b0; else val4 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx4 !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b want=1", tx4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy4); end
    checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", ready4); end
    checks++; if (tx2 !== 1'b1) begin errors++; $display("FAIL rst_tx2 got=%b want=1", tx2); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", ready4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_release_busy got=%b want=0", busy4); end
  endtask

  task automatic test_single(input logic [15:0] w);
    win4 = w; val4 = 1'b1;
    capture(1'b0, 241, 1'b1, -1, 16'h0, 1'b0, -1);
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (decode(0, j, 4) !== exp_char(w, j)) begin
        errors++; $display("FAIL single_byte%0d word=%h got=%h want=%h", j, w, decode(0, j, 4), exp_char(w, j));
      end
    end
    checks++; if (wave_errs(0, w, 4) != 0) begin errors++; $display("FAIL single_wave word=%h bad_cycles=%0d want=0", w, wave_errs(0, w, 4)); end
    checks++; if (count_hi(0, 0, 239) != 240) begin errors++; $display("FAIL single_busy got=%0d want=240", count_hi(0, 0, 239)); end
    checks++; if (count_hi(1, 0, 239) != 0) begin errors++; $display("FAIL single_ready got=%0d want=0", count_hi(1, 0, 239)); end
    checks++; if ({tx_s[240], busy_s[240], rdy_s[240]} !== 3'b101) begin
      errors++; $display("FAIL single_end tx/busy/ready got=%b%b%b want=101", tx_s[240], busy_s[240], rdy_s[240]);
    end
  endtask

  task automatic test_back_to_back();
    win4 = 16'h0000; val4 = 1'b1;
    capture(1'b0, 482, 1'b0, 0, 16'hFFFF, 1'b1, 241);
    checks++; if (wave_errs(0, 16'h0000, 4) != 0) begin errors++; $display("FAIL b2b_wave0 bad_cycles=%0d want=0", wave_errs(0, 16'h0000, 4)); end
    checks++; if (wave_errs(241, 16'hFFFF, 4) != 0) begin errors++; $display("FAIL b2b_wave1 bad_cycles=%0d want=0", wave_errs(241, 16'hFFFF, 4)); end
    checks++; if ({tx_s[240], busy_s[240], rdy_s[240]} !== 3'b101) begin
      errors++; $display("FAIL b2b_gap tx/busy/ready got=%b%b%b want=101", tx_s[240], busy_s[240], rdy_s[240]);
    end
    checks++; if (count_hi(1, 0, 480) != 1) begin errors++; $display("FAIL b2b_ready_cycles got=%0d want=1", count_hi(1, 0, 480)); end
    checks++; if (count_hi(3, 0, 480) != 0 && tx_s[239] !== 1'b1) begin errors++; $display("FAIL b2b_stop_before_gap got=%b want=1", tx_s[239]); end
    checks++; if (tx_s[241] !== 1'b0) begin errors++; $display("FAIL b2b_second_start got=%b want=0", tx_s[241]); end
  endtask

  task automatic test_word_change();
    win4 = 16'hABCD; val4 = 1'b1;
    capture(1'b0, 241, 1'b1, 90, 16'h5555, 1'b0, -1);
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (decode(0, j, 4) !== exp_char(16'hABCD, j)) begin
        errors++; $display("FAIL change_byte%0d got=%h want=%h", j, decode(0, j, 4), exp_char(16'hABCD, j));
      end
    end
    checks++; if (wave_errs(0, 16'hABCD, 4) != 0) begin errors++; $display("FAIL change_wave bad_cycles=%0d want=0", wave_errs(0, 16'hABCD, 4)); end
  endtask

  task automatic test_reset_abort();
    win4 = 16'h1A3F; val4 = 1'b1;
    capture(1'b0, 51, 1'b1, -1, 16'h0, 1'b0, -1);
    checks++; if (tx_s[50] !== exp_tx(16'h1A3F, 50, 4)) begin errors++; $display("FAIL abort_pre got=%b want=%b", tx_s[50], exp_tx(16'h1A3F, 50, 4)); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (tx4 !== 1'b1) begin errors++; $display("FAIL abort_tx got=%b want=1", tx4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy4); end
    checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b want=0", ready4); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL abort_release_ready got=%b want=1", ready4); end
    capture(1'b0, 300, 1'b0, -1, 16'h0, 1'b0, -1);
    checks++; if (count_hi(3, 0, 299) != 0) begin errors++; $display("FAIL abort_tx_quiet low_cycles=%0d want=0", count_hi(3, 0, 299)); end
    checks++; if (count_hi(0, 0, 299) != 0) begin errors++; $display("FAIL abort_busy_quiet got=%0d want=0", count_hi(0, 0, 299)); end
  endtask

  task automatic test_clk2();
    win2 = 16'h9E07; val2 = 1'b1;
    capture(1'b1, 121, 1'b1, -1, 16'h0, 1'b0, -1);
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (decode(0, j, 2) !== exp_char(16'h9E07, j)) begin
        errors++; $display("FAIL clk2_byte%0d got=%h want=%h", j, decode(0, j, 2), exp_char(16'h9E07, j));
      end
    end
    checks++; if (wave_errs(0, 16'h9E07, 2) != 0) begin errors++; $display("FAIL clk2_wave bad_cycles=%0d want=0", wave_errs(0, 16'h9E07, 2)); end
    checks++; if (count_hi(0, 0, 119) != 120) begin errors++; $display("FAIL clk2_busy got=%0d want=120", count_hi(0, 0, 119)); end
    checks++; if ({tx_s[120], busy_s[120], rdy_s[120]} !== 3'b101) begin
      errors++; $display("FAIL clk2_end tx/busy/ready got=%b%b%b want=101", tx_s[120], busy_s[120], rdy_s[120]);
    end
  endtask

  task automatic test_busy_valid(input logic [15:0] w0, input logic [15:0] w1);
    win4 = w0; val4 = 1'b1;
    capture(1'b0, 482, 1'b1, 100, w1, 1'b1, 241);
    checks++; if (count_hi(2, 0, 481) != 0) begin errors++; $display("FAIL busyv_overlap got=%0d want=0", count_hi(2, 0, 481)); end
    checks++; if (count_hi(1, 0, 239) != 0) begin errors++; $display("FAIL busyv_early_ready got=%0d want=0", count_hi(1, 0, 239)); end
    checks++; if (rdy_s[240] !== 1'b1) begin errors++; $display("FAIL busyv_ready_at_idle got=%b want=1", rdy_s[240]); end
    checks++; if (wave_errs(0, w0, 4) != 0) begin errors++; $display("FAIL busyv_wave0 word=%h bad_cycles=%0d want=0", w0, wave_errs(0, w0, 4)); end
    checks++; if (wave_errs(241, w1, 4) != 0) begin errors++; $display("FAIL busyv_wave1 word=%h bad_cycles=%0d want=0", w1, wave_errs(241, w1, 4)); end
    checks++; if (rdy_s[481] !== 1'b1) begin errors++; $display("FAIL busyv_final_ready got=%b want=1", rdy_s[481]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(16'h1A3F);
    for (int r = 0; r < 3; r++) test_single(16'($urandom));
    test_back_to_back();
    test_word_change();
    test_reset_abort();
    test_clk2();
    test_busy_valid(16'($urandom), 16'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
